// File: rtl/copro_dispatch_if.sv
// Requester/coprocessor handshake bundle for copro_dispatch.
// The slave modport is the dispatcher's view; master is the environment's view.
interface copro_dispatch_if #(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 16
);
    logic [WIDTH-1:0]        in_req;
    logic [WIDTH*DATA_W-1:0] in_opd;
    logic [WIDTH-1:0]        out_ack;
    logic                    out_start;
    logic [DATA_W-1:0]       out_opd;
    logic                    in_done;
    logic [DATA_W-1:0]       in_result;
    logic [WIDTH-1:0]        out_valid;
    logic [DATA_W-1:0]       out_result;
    logic                    out_busy;
    logic                    out_timeout;

    modport slave (
        input  in_req, in_opd, in_done, in_result,
        output out_ack, out_start, out_opd, out_valid, out_result, out_busy, out_timeout
    );

    modport master (
        output in_req, in_opd, in_done, in_result,
        input  out_ack, out_start, out_opd, out_valid, out_result, out_busy, out_timeout
    );
endinterface

// File: rtl/copro_dispatch.sv
// Round-robin dispatcher sharing one coprocessor between WIDTH requesters.
// Define COPRO_TIMEOUT_EN to abort jobs that wait TIMEOUT cycles without in_done.
module copro_dispatch #(
    parameter int WIDTH   = 4,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              in_clk,
    input  logic              in_reset,
    copro_dispatch_if.slave   bus
);

    localparam int IDX_W = $clog2(WIDTH);

    if (WIDTH < 2 || WIDTH > 16 || DATA_W < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("copro_dispatch: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, RETURN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  base_q, base_d;
    logic [WIDTH-1:0]  grant_q, grant_d;
    logic [WIDTH-1:0]  ack_q, ack_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] opd_q, opd_d;
    logic [WIDTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              busy_q, busy_d;
`ifdef COPRO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              timeout_q, timeout_d;
`endif

    logic [IDX_W-1:0]   base_idx;
    logic [2*WIDTH-1:0] req_rot_dbl, grant_dbl;
    logic [WIDTH-1:0]   req_rot, low_bit, arb_grant;
    logic [DATA_W-1:0]  arb_opd;

    // Rotate requests so r_base sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        base_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (base_q[i]) base_idx = IDX_W'(i);
        end
        req_rot_dbl = {bus.in_req, bus.in_req} >> base_idx;
        req_rot     = req_rot_dbl[WIDTH-1:0];
        low_bit     = req_rot & (~req_rot + WIDTH'(1));
        grant_dbl   = {{WIDTH{1'b0}}, low_bit} << base_idx;
        arb_grant   = grant_dbl[WIDTH-1:0] | grant_dbl[2*WIDTH-1:WIDTH];
        arb_opd     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (arb_grant[i]) arb_opd = bus.in_opd[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        grant_d  = grant_q;
        ack_d    = '0;
        start_d  = 1'b0;
        opd_d    = opd_q;
        valid_d  = '0;
        result_d = result_q;
`ifdef COPRO_TIMEOUT_EN
        cnt_d     = cnt_q;
        cnt_inc   = cnt_q + CNT_W'(1);
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|bus.in_req) state_d = ARB;
            end
            ARB: begin
                if (!(|bus.in_req)) begin
                    state_d = IDLE;
                end else begin
                    grant_d = arb_grant;
                    opd_d   = arb_opd;
                    ack_d   = arb_grant;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef COPRO_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            WAIT: begin
                if (bus.in_done) begin
                    result_d = bus.in_result;
                    valid_d  = grant_q;
                    state_d  = RETURN;
                end
`ifdef COPRO_TIMEOUT_EN
                else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    result_d  = '0;
                    valid_d   = grant_q;
                    timeout_d = 1'b1;
                    state_d   = RETURN;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            RETURN: begin
                // The requester just served becomes lowest priority.
                base_d  = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
                state_d = (|bus.in_req) ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q  <= IDLE;
            base_q   <= WIDTH'(1);
            grant_q  <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            opd_q    <= '0;
            valid_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
`ifdef COPRO_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            start_q  <= start_d;
            opd_q    <= opd_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            busy_q   <= busy_d;
`ifdef COPRO_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.out_ack    = ack_q;
    assign bus.out_start  = start_q;
    assign bus.out_opd    = opd_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.out_busy   = busy_q;
`ifdef COPRO_TIMEOUT_EN
    assign bus.out_timeout = timeout_q;
`else
    assign bus.out_timeout = 1'b0;
`endif

endmodule

// File: doc/copro_dispatch.md
COPRO_DISPATCH -- requirements
Module: copro_dispatch

Interface
REQ-001 Parameter WIDTH, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter DATA_W, default 16, operand/result width.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles; used only with COPRO_TIMEOUT_EN.
REQ-004 in_clk  input  1  clock; all state updates on rising edge.
REQ-005 in_reset  input  1  reset; asynchronous, active-low.
REQ-006 in_req  input  WIDTH  per-requester request level, held until that requester sees its out_valid bit.
REQ-007 in_opd  input  WIDTH*DATA_W  flat operand bus; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 out_ack  output  WIDTH  one-hot, one-cycle acceptance pulse to the granted requester.
REQ-009 out_start  output  1  one-cycle start pulse to the shared coprocessor.
REQ-010 out_opd  output  DATA_W  registered operand of the granted requester, stable from ISSUE through RETURN.
REQ-011 in_done  input  1  coprocessor completion strobe.
REQ-012 in_result  input  DATA_W  coprocessor result, valid with in_done.
REQ-013 out_valid  output  WIDTH  one-hot, one-cycle result-delivery pulse.
REQ-014 out_result  output  DATA_W  registered result, valid while out_valid nonzero.
REQ-015 out_busy  output  1  high in every state except IDLE.
REQ-016 out_timeout  output  1  one-cycle pulse with out_valid when the job timed out.

Function
REQ-017 FSM states: IDLE, ARB, ISSUE, WAIT, RETURN; all outputs registered.
REQ-018 IDLE: in_req != 0 -> ARB; else stay.
REQ-019 ARB: in_req == 0 -> IDLE; else latch one-hot grant = first set in_req bit searching upward from r_base with wrap-around, latch that requester's operand into out_opd, -> ISSUE.
REQ-020 ISSUE: out_start = 1 and out_ack = grant for exactly this cycle; -> WAIT.
REQ-021 WAIT: on in_done capture in_result into out_result, -> RETURN; in_done in any other state is ignored.
REQ-022 RETURN: out_valid = grant for this cycle only; r_base <= grant rotated left by one (MSB wraps to bit 0); -> ARB if in_req != 0, else IDLE.
REQ-023 Latency: in_req set before edge k gives out_start/out_ack high after edge k+1; in_done at edge m gives out_valid high after edge m.
REQ-024 A requester holding in_req through RETURN is lowest priority at the next ARB; no requester waits more than WIDTH-1 other grants.
REQ-025 in_req bits dropping after ARB do not abort the job; the job completes and out_valid still pulses.

Reset
REQ-026 In-reset low forces immediately: state IDLE, r_base = 1 (requester 0 highest), all outputs 0, timeout counter 0.
REQ-027 Reset mid-operation discards the job; no out_valid is produced for it.

Configuration
REQ-028 Macro COPRO_TIMEOUT_EN defined: a counter cleared on WAIT entry increments each WAIT cycle; reaching TIMEOUT without in_done -> RETURN with out_result = 0 and out_timeout = 1.
REQ-029 Macro undefined: WAIT exits only on in_done; out_timeout is constant 0; no counter logic.

Verification (WIDTH=4, DATA_W=16)
REQ-030 in_req=0010, opd1=0x1234 -> out_ack=0010 and out_start two edges later, out_opd=0x1234; in_done with 0xBEEF -> out_valid=0010, out_result=0xBEEF next cycle.
REQ-031 in_req=1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001.
REQ-032 After grant 0100, in_req=1001 -> next grant 1000.
REQ-033 in_done asserted during ISSUE and never again -> no out_valid; out_busy stays 1 (macro off).
REQ-034 COPRO_TIMEOUT_EN, TIMEOUT=8, no in_done -> after 8 WAIT cycles out_valid=grant, out_result=0, out_timeout=1.
REQ-035 in_reset low during WAIT -> all outputs 0 at once; after release with in_req=1100 first grant 0100.
